// File: rtl/alu_cmd_issue.sv
// Command issue stage for the 3-bit ALU: a small FIFO feeding one registered
// output slot with valid/ready handshakes on both sides and an issue counter.
package alu_cmd_issue_pkg;
  typedef struct packed {
    logic [1:0] op;
    logic [2:0] a;
    logic [2:0] b;
  } cmd_t;
endpackage

module alu_cmd_issue
  import alu_cmd_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [2:0]    cmd_a,
  input  logic [2:0]    cmd_b,
  output logic          alu_valid,
  input  logic          alu_ready,
  output logic [2:0]    alu_a,
  output logic [2:0]    alu_b,
  output logic [1:0]    alu_op,
  output logic [AW:0]   fifo_count,
  output logic [7:0]    issue_count
);

  localparam int unsigned CW = AW + 1;

  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_valid;
  cmd_t          r_out;
  logic [7:0]    r_issue;

  logic w_cmd_ready;
  logic w_push;
  logic w_load;
  logic w_fire;
  cmd_t w_cmd;

  // Ready comes from registered occupancy only, never from a same-cycle pop.
  assign w_cmd_ready = rst_n && !flush && (r_count < CW'(DEPTH));
  assign w_push      = cmd_valid && w_cmd_ready;
  assign w_load      = !flush && (!r_valid || alu_ready) && (r_count != '0);
  assign w_fire      = r_valid && alu_ready;
  assign w_cmd       = '{op: cmd_op, a: cmd_a, b: cmd_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= w_cmd;
    end
  end

  // Pointers, occupancy and output slot; flush outranks push and load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_out   <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_push) r_wptr <= AW'(r_wptr + 1'b1);
      if (w_load) begin
        r_rptr  <= AW'(r_rptr + 1'b1);
        r_out   <= r_mem[r_rptr];
        r_valid <= 1'b1;
      end else if (w_fire) begin
        r_valid <= 1'b0;
      end
      case ({w_push, w_load})
        2'b10:   r_count <= CW'(r_count + 1'b1);
        2'b01:   r_count <= CW'(r_count - 1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Counts every downstream handshake, flush included; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue <= '0;
    end else if (w_fire) begin
      r_issue <= 8'(r_issue + 8'd1);
    end
  end

  assign cmd_ready   = w_cmd_ready;
  assign alu_valid   = r_valid;
  assign alu_a       = r_out.a;
  assign alu_b       = r_out.b;
  assign alu_op      = r_out.op;
  assign fifo_count  = r_count;
  assign issue_count = r_issue;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Scoreboard bench for alu_cmd_issue: accepted commands are queued as expected
// outputs and a negedge monitor compares every downstream handshake.
module tb_alu_cmd_issue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_a;
  logic [2:0] cmd_b;
  logic       alu_valid;
  logic       alu_ready;
  logic [2:0] alu_a;
  logic [2:0] alu_b;
  logic [1:0] alu_op;
  logic [2:0] fifo_count;
  logic [7:0] issue_count;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb [$];

  alu_cmd_issue #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .fifo_count(fifo_count), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake seen mid-cycle retires the oldest expected command.
  always @(negedge clk) begin
    if (rst_n && alu_valid && alu_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_issue", {24'd0, alu_op, alu_a, alu_b}, 32'hFFFF_FFFF);
      end else begin
        check("issue_data", {24'd0, alu_op, alu_a, alu_b}, {24'd0, sb.pop_front()});
      end
    end
  end

  task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
    cmd_valid = v;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
  endtask

  task automatic cycle(output bit acc);
    @(negedge clk);
    acc = rst_n && cmd_valid && cmd_ready;
    if (acc) sb.push_back({cmd_op, cmd_a, cmd_b});
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string name, input logic v, input logic [7:0] cmd);
    check({name, "_valid"}, 32'(alu_valid), 32'(v));
    check({name, "_cmd"}, {24'd0, alu_op, alu_a, alu_b}, {24'd0, cmd});
  endtask

  logic [7:0] cmds [20];
  logic [7:0] c8;
  bit acc;
  int idx;
  int guard;

  initial begin
    rst_n = 1'b0; flush = 1'b0; alu_ready = 1'b0;
    drive(1'b0, 2'd0, 3'd0, 3'd0);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    outs("rst", 1'b0, 8'h00);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_issue_count", 32'(issue_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: single command, latency one cycle from acceptance
    alu_ready = 1'b1;
    drive(1'b1, 2'b00, 3'd3, 3'd2);
    cycle(acc);
    check("t1_accept", 32'(acc), 32'd1);
    check("t1_no_bypass", 32'(alu_valid), 32'd0);
    drive(1'b0, 2'd0, 3'd0, 3'd0);
    cycle(acc);
    outs("t1_out", 1'b1, {2'b00, 3'd3, 3'd2});
    cycle(acc);
    check("t1_drain_valid", 32'(alu_valid), 32'd0);
    check("t1_issue", 32'(issue_count), 32'd1);

    // 2: stalled consumer, five back-to-back pushes fill slot and FIFO
    alu_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'(i), 3'(i + 1), 3'(6 - i));
      cycle(acc);
    end
    check("t2_count", 32'(fifo_count), 32'd4);
    check("t2_ready", 32'(cmd_ready), 32'd0);
    outs("t2_head", 1'b1, {2'd0, 3'd1, 3'd6});
    drive(1'b1, 2'b11, 3'd7, 3'd0);
    repeat (2) begin
      cycle(acc);
      check("t2_reject", 32'(acc), 32'd0);
    end
    check("t2_count_hold", 32'(fifo_count), 32'd4);
    outs("t2_stable", 1'b1, {2'd0, 3'd1, 3'd6});
    drive(1'b0, 2'd0, 3'd0, 3'd0);

    // 3: release consumer, drain one per cycle
    alu_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle(acc);
      check("t3_count", 32'(fifo_count), 32'(3 - k));
      check("t3_ready", 32'(cmd_ready), 32'd1);
    end
    cycle(acc);
    check("t3_valid_low", 32'(alu_valid), 32'd0);
    check("t3_issue", 32'(issue_count), 32'd6);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // 4: full FIFO with simultaneous push and pop keeps occupancy constant
    for (int i = 0; i < 20; i++) cmds[i] = 8'($urandom);
    alu_ready = 1'b0;
    idx = 0;
    while (idx < 5) begin
      c8 = cmds[idx];
      drive(1'b1, c8[7:6], c8[5:3], c8[2:0]);
      cycle(acc);
      if (acc) idx++;
    end
    check("t4_full", 32'(fifo_count), 32'd4);
    alu_ready = 1'b1;
    guard = 0;
    while (idx < 20 && guard < 100) begin
      c8 = cmds[idx];
      drive(1'b1, c8[7:6], c8[5:3], c8[2:0]);
      cycle(acc);
      if (acc) idx++;
      guard++;
      check("t4_count_const", 32'(fifo_count), 32'd3);
    end
    check("t4_all_pushed", 32'(idx), 32'd20);
    drive(1'b0, 2'd0, 3'd0, 3'd0);
    guard = 0;
    while ((alu_valid || fifo_count != 0) && guard < 20) begin
      cycle(acc);
      guard++;
    end
    check("t4_drained", 32'(sb.size()), 32'd0);
    check("t4_issue", 32'(issue_count), 32'd26);

    // 5a: flush with consumer stalled discards everything
    alu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b10, 3'(i), 3'(i + 4));
      cycle(acc);
    end
    check("t5_count", 32'(fifo_count), 32'd3);
    flush = 1'b1;
    drive(1'b1, 2'b01, 3'd5, 3'd5);
    #1;
    check("t5_ready_flush", 32'(cmd_ready), 32'd0);
    cycle(acc);
    flush = 1'b0;
    drive(1'b0, 2'd0, 3'd0, 3'd0);
    sb.delete();
    check("t5_count_clr", 32'(fifo_count), 32'd0);
    outs("t5_hold", 1'b0, {2'b10, 3'd0, 3'd4});
    check("t5_issue_same", 32'(issue_count), 32'd26);

    // 5b: flush coinciding with a handshake still counts that issue
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b01, 3'(i + 2), 3'(i));
      cycle(acc);
    end
    drive(1'b0, 2'd0, 3'd0, 3'd0);
    alu_ready = 1'b1;
    flush = 1'b1;
    cycle(acc);
    flush = 1'b0;
    sb.delete();
    check("t5b_valid", 32'(alu_valid), 32'd0);
    check("t5b_count", 32'(fifo_count), 32'd0);
    check("t5b_issue", 32'(issue_count), 32'd27);

    // 6: asynchronous reset mid-burst, then a clean first command
    alu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b11, 3'(i), 3'(i));
      cycle(acc);
    end
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    outs("t6_rst", 1'b0, 8'h00);
    check("t6_count", 32'(fifo_count), 32'd0);
    check("t6_issue", 32'(issue_count), 32'd0);
    check("t6_ready", 32'(cmd_ready), 32'd0);
    drive(1'b0, 2'd0, 3'd0, 3'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    alu_ready = 1'b1;
    drive(1'b1, 2'b11, 3'd7, 3'd7);
    cycle(acc);
    drive(1'b0, 2'd0, 3'd0, 3'd0);
    cycle(acc);
    outs("t6_out", 1'b1, {2'b11, 3'd7, 3'd7});
    cycle(acc);
    check("t6_issue_one", 32'(issue_count), 32'd1);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issue.md
Name: alu_cmd_issue

Overview:
- Upstream feeder for the 3-bit ALU (4-bit result, sign/overflow/zero flags).
- Accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO.
- Presents one command at a time on registered ALU operand lines (alu_a, alu_b, alu_op) with a valid/ready handshake toward the ALU/result stage.
- Decouples bursty command producers from the ALU consumer and counts issued operations.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
AW, 2, pointer width = log2(DEPTH).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous clear of FIFO and output stage.
cmd_valid  input  1  producer has a command.
cmd_ready  output  1  block can accept a command this cycle.
cmd_op  input  2  opcode: 00 add, 01 sub, 10 rem, 11 mul.
cmd_a  input  3  operand A.
cmd_b  input  3  operand B.
alu_valid  output  1  alu_a/alu_b/alu_op hold a valid command.
alu_ready  input  1  downstream consumes the presented command.
alu_a  output  3  registered operand A to the ALU.
alu_b  output  3  registered operand B to the ALU.
alu_op  output  2  registered opcode to the ALU.
fifo_count  output  AW+1  entries currently in the FIFO, excluding the output stage.
issue_count  output  8  number of commands consumed downstream; wraps modulo 256.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: all registers clear asynchronously.
  - cmd_ready = 0 while rst_n = 0.
  - alu_valid = 0; alu_a = alu_b = 0; alu_op = 00.
  - fifo_count = 0; issue_count = 0; FIFO pointers = 0.
- cmd_ready = (fifo_count < DEPTH) && !flush, derived from registered state only. It does not depend on a same-cycle pop.
- Push: on a rising edge with cmd_valid && cmd_ready, {cmd_op, cmd_a, cmd_b} is written at the write pointer. The write pointer increments, wrapping DEPTH-1 -> 0.
- Output load: on a rising edge with (!alu_valid || alu_ready) && fifo_count > 0:
  - the FIFO head is copied into alu_a/alu_b/alu_op;
  - alu_valid = 1;
  - the read pointer increments with wrap.
- Output drain: on a rising edge with alu_valid && alu_ready && fifo_count == 0, alu_valid drops to 0. alu_a/alu_b/alu_op hold their last values.
- Stall: while alu_valid && !alu_ready, alu_a/alu_b/alu_op/alu_valid are held stable, with no change permitted.
- No bypass: a command accepted at edge N appears on alu_* at edge N+1 at the earliest. Minimum latency is 1 cycle from acceptance; one push per cycle maximum.
- Throughput: 1 command/cycle sustained when alu_ready is held high.
- Push and pop on the same edge: fifo_count is unchanged, including when the FIFO is full. cmd_ready is low when full, so no push can occur while full.
- issue_count increments on every edge where alu_valid && alu_ready. It wraps 255 -> 0 and is not cleared by flush.
- Flush (synchronous, highest priority):
  - on an edge with flush = 1, pointers clear, fifo_count = 0 and alu_valid = 0;
  - no push or load occurs that edge;
  - alu_a/alu_b/alu_op hold their values;
  - a handshake on alu_valid && alu_ready in that same cycle still counts in issue_count.
- Reset mid-operation: all in-flight commands are discarded immediately. There is no partial output.
- FIFO ordering is strict first-in, first-out. Commands are never dropped or duplicated.

Test Plan:
1. Reset, then push (op=00, A=3, B=2) with alu_ready=1 -> edge after accept: alu_valid=1, alu_a=3, alu_b=2, alu_op=00; next edge alu_valid=0; issue_count=1.
2. alu_ready=0; push 5 commands back-to-back -> 1st in output stage, fifo_count=4, cmd_ready=0; the 6th cmd_valid is not accepted and the outputs stay stable.
3. From state 2, raise alu_ready continuously -> the 5 commands emerge in order on consecutive cycles; fifo_count steps 4,3,2,1,0; issue_count +5; cmd_ready returns to 1 after the first pop edge.
4. Full FIFO, alu_ready=1 and cmd_valid=1 each cycle -> the push accepted once fifo_count < 4 with simultaneous pop holds fifo_count constant; ordering is verified over 20 random commands.
5. With 3 queued and alu_valid=1, assert flush one cycle -> fifo_count=0, alu_valid=0, cmd_ready=0 that cycle; issue_count is unchanged unless alu_ready=1.
6. Deassert rst_n mid-burst (asynchronously, between edges) -> outputs clear immediately; after release, the first new command (op=11, A=7, B=7) is issued correctly with issue_count=1.
